// File: rtl/scr1_brq_pkg.sv
// Branch resolution queue shared types.
// Record layout, FSM states and fall-through helpers.
package scr1_brq_pkg;

  localparam int BRQ_XLEN = 32;

  localparam logic [BRQ_XLEN-1:0] BRQ_FALLTHRU_RVI = 32'd4;
  localparam logic [BRQ_XLEN-1:0] BRQ_FALLTHRU_RVC = 32'd2;

  typedef struct packed {
    logic [BRQ_XLEN-1:0] pc;
    logic                rvi;
    logic                pred_taken;
    logic [BRQ_XLEN-1:0] pred_pc;
    logic                btb_hit;
  } brq_rec_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } brq_state_e;

  function automatic logic [BRQ_XLEN-1:0] brq_fallthru(
    input logic [BRQ_XLEN-1:0] pc,
    input logic                rvi
  );
    return pc + (rvi ? BRQ_FALLTHRU_RVI
                     : BRQ_FALLTHRU_RVC);
  endfunction

endpackage

// File: rtl/scr1_brq_fifo.sv
// Pointer-based FIFO of prediction records.
// Clear has priority over push and pop.
module scr1_brq_fifo
  import scr1_brq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  logic     i_pop,
  input  logic     i_clear,
  input  brq_rec_t i_wdata,
  output brq_rec_t o_rdata,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  brq_rec_t    r_mem [DEPTH];

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW])
                && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push && !i_clear) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/scr1_branch_resolve.sv
// EXU branch resolution queue: retire compare, BPU update, IFU redirect.
// SCR1_BRQ_STATS_EN adds retired-branch and mispredict counters.
module scr1_branch_resolve
  import scr1_brq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = BRQ_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ifu2brq_push_i,
  input  logic [XLEN-1:0] ifu2brq_pc_i,
  input  logic            ifu2brq_rvi_i,
  input  logic            ifu2brq_pred_taken_i,
  input  logic [XLEN-1:0] ifu2brq_pred_pc_i,
  input  logic            ifu2brq_btb_hit_i,
  output logic            brq2ifu_full_o,
  input  logic            exu2brq_retire_i,
  input  logic            exu2brq_is_branch_i,
  input  logic            exu2brq_taken_i,
  input  logic [XLEN-1:0] exu2brq_target_i,
  input  logic            exu2brq_flush_i,
  output logic            brq2ifu_new_pc_req_o,
  output logic [XLEN-1:0] brq2ifu_new_pc_o,
  output logic            brq2bpu_upd_vld_o,
  output logic            brq2bpu_b_type_o,
  output logic [XLEN-1:0] brq2bpu_pc_prev_o,
  output logic            brq2bpu_pc_new_req_o,
  output logic [XLEN-1:0] brq2bpu_pc_new_o,
  output logic            brq2bpu_prev_prediction_o,
  output logic            brq2bpu_btb_miss_o,
  output logic            brq2ifu_rvi_o,
  output logic            brq_err_o
`ifdef SCR1_BRQ_STATS_EN
  ,
  output logic [31:0]     stat_branches_o,
  output logic [31:0]     stat_mispred_o
`endif
);

  brq_rec_t        w_wr_rec;
  brq_rec_t        w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_ret;
  logic            w_push;
  logic            w_clear;
  logic            w_mispred;
  logic            w_upd;
  logic            w_redir;
  logic            w_br;
  logic            w_tk;
  logic [XLEN-1:0] w_next_pc;
  brq_state_e      r_state;
  brq_state_e      w_state_nxt;

  assign w_wr_rec = '{
    pc:         ifu2brq_pc_i,
    rvi:        ifu2brq_rvi_i,
    pred_taken: ifu2brq_pred_taken_i,
    pred_pc:    ifu2brq_pred_pc_i,
    btb_hit:    ifu2brq_btb_hit_i
  };

  assign w_br  = exu2brq_is_branch_i;
  assign w_tk  = exu2brq_taken_i;
  assign w_ret = exu2brq_retire_i & ~w_empty;

  // A retire frees the head slot, so a full queue can still accept.
  assign w_push = ifu2brq_push_i
                & (r_state == RUN)
                & ~exu2brq_flush_i
                & (~w_full | w_ret);

  always_comb begin
    w_mispred = 1'b0;
    if (w_ret) begin
      if (w_br) begin
        w_mispred = (w_tk != w_head.pred_taken)
                  | (w_tk & w_head.pred_taken
                     & (exu2brq_target_i != w_head.pred_pc));
      end else begin
        w_mispred = w_head.pred_taken;
      end
    end
  end

  assign w_upd     = w_ret & (w_br | w_head.pred_taken);
  assign w_redir   = w_mispred & ~exu2brq_flush_i;
  assign w_clear   = exu2brq_flush_i | w_mispred;
  assign w_next_pc = w_tk ? exu2brq_target_i
                          : brq_fallthru(w_head.pc, w_head.rvi);

  scr1_brq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_ret),
    .i_clear (w_clear),
    .i_wdata (w_wr_rec),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign brq2ifu_full_o = w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:   if (w_redir) w_state_nxt = DRAIN;
      DRAIN: w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
    if (exu2brq_flush_i) w_state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brq2ifu_new_pc_req_o      <= 1'b0;
      brq2ifu_new_pc_o          <= '0;
      brq2bpu_upd_vld_o         <= 1'b0;
      brq2bpu_b_type_o          <= 1'b0;
      brq2bpu_pc_prev_o         <= '0;
      brq2bpu_pc_new_req_o      <= 1'b0;
      brq2bpu_pc_new_o          <= '0;
      brq2bpu_prev_prediction_o <= 1'b0;
      brq2bpu_btb_miss_o        <= 1'b0;
      brq2ifu_rvi_o             <= 1'b0;
      brq_err_o                 <= 1'b0;
    end else begin
      brq2ifu_new_pc_req_o      <= w_redir;
      brq2ifu_new_pc_o          <= w_redir ? w_next_pc : '0;
      brq2bpu_upd_vld_o         <= w_upd;
      brq2bpu_b_type_o          <= w_upd & w_br;
      brq2bpu_pc_prev_o         <= w_upd ? w_head.pc : '0;
      brq2bpu_pc_new_req_o      <= w_upd & w_tk & w_br;
      brq2bpu_pc_new_o          <= w_upd ? exu2brq_target_i : '0;
      brq2bpu_prev_prediction_o <= w_upd & w_head.pred_taken;
      brq2bpu_btb_miss_o        <= w_upd & w_br & w_tk
                                 & (~w_head.btb_hit
                                    | (exu2brq_target_i != w_head.pred_pc));
      brq2ifu_rvi_o             <= w_ret & w_head.rvi;
      if (exu2brq_retire_i && w_empty) brq_err_o <= 1'b1;
    end
  end

`ifdef SCR1_BRQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_o <= '0;
      stat_mispred_o  <= '0;
    end else begin
      if (w_ret && w_br && (stat_branches_o != '1))
        stat_branches_o <= stat_branches_o + 32'd1;
      if (w_mispred && (stat_mispred_o != '1))
        stat_mispred_o <= stat_mispred_o + 32'd1;
    end
  end
`endif

endmodule
